// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result path: default widths, buffer
// depth and the result_reader sequencing states.
package matrix_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 4;

    // Depth of the return buffer; also the cap on buffered-plus-in-flight words.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rr_state_e;

    // Counter width able to hold the values 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry return buffer for result words coming back from the result
// memory. A read and a write in the same cycle leave the occupancy unchanged
// and keep the words in order. The head word is presented combinationally.
module result_fifo
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              do_wr;
    logic              do_rd;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

    // A write into a full buffer is legal only when the head leaves in the
    // same cycle; the write then reuses the slot being vacated.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage clears on reset so the
    // presented word reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/result_reader.sv
// Reads NUM_RES consecutive result words from the result memory, starting
// at a latched base address, and streams them out over a valid/ready port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; base_addr is latched on acceptance
//   ST_READ  | issuing memory reads whenever buffer credit allows
//   ST_DRAIN | all reads issued; waiting for the last word to be accepted
//   ST_DONE  | one-cycle done pulse, then back to idle
module result_reader
    import matrix_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W    = count_width(NUM_RES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_RES - 1);
    localparam logic [2:0]       CREDIT   = 3'(FIFO_DEPTH);

    rr_state_e         state;
    rr_state_e         state_nxt;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  acc_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              inflight;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;

    logic              start_acc;
    logic              pop;
    logic [2:0]        occ_after_pop;
    logic              credit_ok;
    logic              last_issue;
    logic              last_accept;

    assign start_acc = (state == ST_IDLE) && start;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid && out_ready;

    // Credit counts words already buffered plus the read still in flight,
    // less the word leaving this cycle. Counting the departing word lets a
    // new read overlap the handshake so a ready sink sees one word per cycle.
    // A full buffer never issues, even when it is draining.
    assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign credit_ok     = !fifo_full && (occ_after_pop < CREDIT);

    assign last_issue  = mem_ren && (issue_cnt == LAST_IDX);
    assign last_accept = pop && (acc_cnt == LAST_IDX);

    // Between reads the port shows the last issued address rather than the
    // next one.
    assign mem_addr = mem_ren ? rd_addr : last_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only looked at in idle, so a start during
    // a job is dropped rather than queued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)       state_nxt = ST_READ;
            ST_READ:  if (last_issue)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_accept) state_nxt = ST_DONE;
            ST_DONE:                   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        mem_ren = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            ST_IDLE:  busy    = 1'b0;
            ST_READ:  mem_ren = credit_ok;
            ST_DRAIN: mem_ren = 1'b0;
            ST_DONE:  done    = 1'b1;
            default:  busy    = 1'b0;
        endcase
    end

    // Address, issue/accept counters and the in-flight flag. Clearing the
    // in-flight flag on reset discards a word returning right after an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            last_addr <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= mem_ren;
            if (start_acc) begin
                rd_addr   <= base_addr;
                issue_cnt <= '0;
                acc_cnt   <= '0;
            end else begin
                if (mem_ren) begin
                    rd_addr   <= rd_addr + 1'b1;
                    last_addr <= rd_addr;
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (pop) begin
                    acc_cnt <= acc_cnt + 1'b1;
                end
            end
        end
    end

    // Return buffer. Memory data is valid exactly one cycle after the read
    // strobe, so the in-flight flag doubles as the write enable.
    result_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (mem_rdata),
        .rd_en   (pop),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a behavioural result memory, an
// expected-word queue filled at start time and drained on handshakes, and a
// small occupancy model used to check read credit and out_valid.
module tb_result_reader;

    localparam int DW = 20;
    localparam int AW = 4;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    result_reader #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RES (NR)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Result memory preloaded with word k = 0x00100 * k, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= DW'(mem_addr) * 20'h00100;
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    int            reads_issued = 0;
    int            words_seen = 0;
    int            done_count = 0;
    int            buf_m = 0;
    int            t = 0;
    int            first_valid_t = -1;
    int            last_hs_t = -1;
    int            done_t = -1;
    bit            inflight_m = 1'b0;
    bit            prev_stall = 1'b0;
    bit            job_on = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return DW'(a) * 20'h00100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Per-cycle observation, sampled on the falling edge.
    task automatic monitor();
        bit pop;
        pop = out_valid && out_ready;
        if (rst) begin
            buf_m      = 0;
            inflight_m = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        chk("valid_vs_buffered", 32'(out_valid), 32'(buf_m != 0));
        chk("busy", 32'(busy), 32'(job_on));
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (mem_ren) begin
            chk("ren_with_2_buffered", 32'(buf_m < 2), 32'd1);
            chk("ren_over_credit", 32'((buf_m + int'(inflight_m) - int'(pop)) < 2), 32'd1);
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            exp_addr++;
            reads_issued++;
        end
        if (out_valid && first_valid_t < 0) first_valid_t = t;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            words_seen++;
            last_hs_t = t;
        end
        if (done) begin
            chk("done_with_valid", 32'(out_valid), 32'd0);
            done_count++;
            done_t = t;
            job_on = 1'b0;
        end
        buf_m      = buf_m + int'(inflight_m) - int'(pop);
        inflight_m = mem_ren;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_ren"},   32'(mem_ren),   32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0,1,0,1; 2: ready low for
    // the first 10 cycles after start. restart_at >= 0 pulses start mid-job.
    task automatic run_job(input logic [AW-1:0] base, input int mode, input int restart_at);
        logic [AW-1:0] a;
        int            start_t;
        a = base;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            exp_q.push_back(word_at(a));
            a++;
        end
        exp_addr      = base;
        reads_issued  = 0;
        words_seen    = 0;
        done_count    = 0;
        first_valid_t = -1;
        last_hs_t     = -1;
        done_t        = -1;
        base_addr     = base;
        out_ready     = (mode != 2);
        start         = 1'b1;
        start_t       = t;
        tick();
        start  = 1'b0;
        job_on = 1'b1;
        for (int n = 0; n < 200 && done_count == 0; n++) begin
            start     = (n == restart_at);
            base_addr = (n == restart_at) ? (base ^ 4'h9) : base;
            case (mode)
                1:       out_ready = pat[n % 6];
                2:       out_ready = (n >= 10);
                default: out_ready = 1'b1;
            endcase
            tick();
            if (mode == 2 && n == 9) begin
                chk("stall_reads", 32'(reads_issued), 32'd2);
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_data", 32'(out_data), 32'(word_at(base)));
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("job_done_count", 32'(done_count), 32'd1);
        chk("job_words", 32'(words_seen), 32'(NR));
        chk("job_reads", 32'(reads_issued), 32'(NR));
        chk("job_queue_left", 32'(exp_q.size()), 32'd0);
        chk("done_after_last", 32'(done_t), 32'(last_hs_t + 1));
        if (mode == 0) begin
            chk("first_valid_latency", 32'(first_valid_t), 32'(start_t + 3));
            chk("last_handshake", 32'(last_hs_t), 32'(start_t + 3 + NR - 1));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        #1;
        tick();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        tick();

        run_job(4'd0, 0, -1);
        tick();
        run_job(4'd14, 0, -1);
        run_job(4'd3, 1, -1);
        run_job(4'd7, 2, -1);
        run_job(4'd1, 0, 3);
        tick();

        // Abort three cycles into a job, then run a clean job from address 5.
        exp_q.delete();
        for (int i = 0; i < NR; i++) exp_q.push_back(word_at(4'(2 + i)));
        exp_addr   = 4'd2;
        done_count = 0;
        base_addr  = 4'd2;
        out_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start  = 1'b0;
        job_on = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst    = 1'b0;
        job_on = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", 32'(done_count), 32'd0);
        run_job(4'd5, 0, -1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
